// File: rtl/ex_mem_latch_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_latch_if
// Description : EX->MEM pipeline register bus (EX inputs, MEM-side outputs).
// Revision    : 1.0
// ============================================================================
interface ex_mem_latch_if;
  logic [15:0] exmemi_instr;
  logic [15:0] exmemi_pc;
  logic [15:0] exmemi_data;
  logic [3:0]  exmemi_wreg_addr;
  logic [15:0] exmemi_write_to_mem_data;
  logic [1:0]  exmemi_rwe;
  logic        exmemi_stall;
  logic        exmemi_flush;
  logic        exmemi_uart_writeable;
  logic        exmemi_uart_data_ready;

  logic [15:0] exmemo_instr;
  logic [15:0] exmemo_pc;
  logic [15:0] exmemo_data;
  logic [3:0]  exmemo_wreg_addr;
  logic [15:0] exmemo_write_to_mem_data;
  logic [1:0]  exmemo_rwe;
  logic        exmemo_stall_req;

  modport slave (
    input  exmemi_instr, exmemi_pc, exmemi_data, exmemi_wreg_addr,
           exmemi_write_to_mem_data, exmemi_rwe, exmemi_stall, exmemi_flush,
           exmemi_uart_writeable, exmemi_uart_data_ready,
    output exmemo_instr, exmemo_pc, exmemo_data, exmemo_wreg_addr,
           exmemo_write_to_mem_data, exmemo_rwe, exmemo_stall_req
  );

  modport master (
    output exmemi_instr, exmemi_pc, exmemi_data, exmemi_wreg_addr,
           exmemi_write_to_mem_data, exmemi_rwe, exmemi_stall, exmemi_flush,
           exmemi_uart_writeable, exmemi_uart_data_ready,
    input  exmemo_instr, exmemo_pc, exmemo_data, exmemo_wreg_addr,
           exmemo_write_to_mem_data, exmemo_rwe, exmemo_stall_req
  );
endinterface
`default_nettype wire

// File: rtl/ex_mem_latch.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_latch
// Description : EX/MEM pipeline register with RAM-store stretching and UART
//               store holding. Option macro: EXMEM_UART_READ_WAIT_EN.
// Revision    : 1.0
// ============================================================================
module ex_mem_latch #(
  parameter int unsigned WR_CYCLES = 2,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  wire logic       exmemi_clk,
  input  wire logic       exmemi_rst,
  ex_mem_latch_if.slave   bus
);

  localparam logic [1:0]  C_RWE_NOP        = 2'b00;
  localparam logic [1:0]  C_RWE_READ_MEM   = 2'b01;
  localparam logic [1:0]  C_RWE_WRITE_MEM  = 2'b10;
  localparam logic [15:0] C_ADDR_SERIAL    = 16'hBF00;
  localparam logic [3:0]  C_WR             = 4'(WR_CYCLES);

  typedef enum logic [1:0] {
    ST_PASS      = 2'd0,
    ST_WR_HOLD   = 2'd1,
    ST_UART_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic        flush_pend_q, flush_pend_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  wreg_q, wreg_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  rwe_q, rwe_d;

  logic        uart_ready;
  logic        stall_req;
  logic [1:0]  rwe_out;
  logic        ex_serial;

  assign ex_serial = (bus.exmemi_data == C_ADDR_SERIAL);

  // Output side: depends only on state, count and the UART flags.
  always_comb begin
    uart_ready = bus.exmemi_uart_writeable;
`ifdef EXMEM_UART_READ_WAIT_EN
    if (rwe_q == C_RWE_READ_MEM) uart_ready = bus.exmemi_uart_data_ready;
`endif
    stall_req = 1'b0;
    rwe_out   = rwe_q;
    case (state_q)
      ST_WR_HOLD: begin
        stall_req = (count_q < C_WR);
        rwe_out   = C_RWE_WRITE_MEM;
      end
      ST_UART_WAIT: begin
        stall_req = ~uart_ready;
        rwe_out   = uart_ready ? rwe_q : C_RWE_NOP;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    flush_pend_d = flush_pend_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    data_d       = data_q;
    wreg_d       = wreg_q;
    wdata_d      = wdata_q;
    rwe_d        = rwe_q;
    if (stall_req) begin
      // A held store is never killed; a flush seen now bubbles the EX op later.
      if (bus.exmemi_flush) flush_pend_d = 1'b1;
      if (state_q == ST_WR_HOLD) count_d = count_q + 4'd1;
    end else begin
      state_d = ST_PASS;
      count_d = 4'd0;
      if (bus.exmemi_flush || flush_pend_q) begin
        instr_d      = NOP_INSTR;
        pc_d         = bus.exmemi_pc;
        data_d       = 16'h0000;
        wreg_d       = 4'h0;
        wdata_d      = 16'h0000;
        rwe_d        = C_RWE_NOP;
        flush_pend_d = 1'b0;
      end else if (!bus.exmemi_stall) begin
        instr_d = bus.exmemi_instr;
        pc_d    = bus.exmemi_pc;
        data_d  = bus.exmemi_data;
        wreg_d  = bus.exmemi_wreg_addr;
        wdata_d = bus.exmemi_write_to_mem_data;
        rwe_d   = bus.exmemi_rwe;
        if (bus.exmemi_rwe == C_RWE_WRITE_MEM && ex_serial) begin
          state_d = ST_UART_WAIT;
        end else if (bus.exmemi_rwe == C_RWE_WRITE_MEM && C_WR > 4'd1) begin
          state_d = ST_WR_HOLD;
          count_d = 4'd1;
        end
`ifdef EXMEM_UART_READ_WAIT_EN
        else if (bus.exmemi_rwe == C_RWE_READ_MEM && ex_serial) begin
          state_d = ST_UART_WAIT;
        end
`endif
      end
    end
  end

  always_ff @(posedge exmemi_clk or posedge exmemi_rst) begin
    if (exmemi_rst) begin
      state_q      <= ST_PASS;
      count_q      <= 4'd0;
      flush_pend_q <= 1'b0;
      instr_q      <= NOP_INSTR;
      pc_q         <= 16'h0000;
      data_q       <= 16'h0000;
      wreg_q       <= 4'h0;
      wdata_q      <= 16'h0000;
      rwe_q        <= C_RWE_NOP;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      flush_pend_q <= flush_pend_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      data_q       <= data_d;
      wreg_q       <= wreg_d;
      wdata_q      <= wdata_d;
      rwe_q        <= rwe_d;
    end
  end

  assign bus.exmemo_instr             = instr_q;
  assign bus.exmemo_pc                = pc_q;
  assign bus.exmemo_data              = data_q;
  assign bus.exmemo_wreg_addr         = wreg_q;
  assign bus.exmemo_write_to_mem_data = wdata_q;
  assign bus.exmemo_rwe               = rwe_out;
  assign bus.exmemo_stall_req         = stall_req;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_latch
// Description : Self-checking bench for ex_mem_latch (directed + random).
// Revision    : 1.0
// ============================================================================
module tb_ex_mem_latch;
  localparam int          WR     = 2;
  localparam logic [15:0] NOP    = 16'h0800;
  localparam logic [15:0] SERIAL = 16'hBF00;
  localparam logic [1:0]  R_NOP  = 2'b00;
  localparam logic [1:0]  R_RD   = 2'b01;
  localparam logic [1:0]  R_WR   = 2'b10;
`ifdef EXMEM_UART_READ_WAIT_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_mem_latch_if bus();

  ex_mem_latch #(.WR_CYCLES(WR), .NOP_INSTR(NOP)) dut (
    .exmemi_clk (clk),
    .exmemi_rst (rst),
    .bus        (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] instr, pc, data, wdata;
    logic [3:0]  wreg;
    logic [1:0]  rwe;
    bit          bubble;
  } op_t;

  // Model: the op on the MEM side, what kind of wait it is in, and how many
  // more stall cycles a RAM store still owes.
  op_t m_op;
  int  m_mode;   // 0 pass-through, 1 RAM store stretch, 2 UART wait
  int  m_left;
  bit  m_fp;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_op.instr = NOP; m_op.pc = 16'h0; m_op.data = 16'h0; m_op.wdata = 16'h0;
    m_op.wreg = 4'h0; m_op.rwe = R_NOP; m_op.bubble = 1'b0;
    m_mode = 0; m_left = 0; m_fp = 1'b0;
  endtask

  function automatic bit m_ready();
    if (FEAT && m_op.rwe == R_RD) return bus.exmemi_uart_data_ready;
    return bus.exmemi_uart_writeable;
  endfunction

  function automatic bit exp_stall();
    if (m_mode == 1) return m_left > 0;
    if (m_mode == 2) return !m_ready();
    return 1'b0;
  endfunction

  function automatic logic [1:0] exp_rwe();
    if (m_mode == 1) return R_WR;
    if (m_mode == 2) return m_ready() ? m_op.rwe : R_NOP;
    return m_op.rwe;
  endfunction

  task automatic compare();
    chk("stall_req", bus.exmemo_stall_req, exp_stall());
    chk("rwe", bus.exmemo_rwe, exp_rwe());
    chk("instr", bus.exmemo_instr, m_op.instr);
    chk("data", bus.exmemo_data, m_op.data);
    chk("wreg", bus.exmemo_wreg_addr, m_op.wreg);
    if (!m_op.bubble) begin
      chk("pc", bus.exmemo_pc, m_op.pc);
      chk("wdata", bus.exmemo_write_to_mem_data, m_op.wdata);
    end
  endtask

  task automatic model_edge();
    bit held;
    held = exp_stall();
    if (held) begin
      if (m_mode == 1) m_left--;
      if (bus.exmemi_flush) m_fp = 1'b1;
    end else if (bus.exmemi_flush || m_fp) begin
      m_op.instr = NOP; m_op.data = 16'h0; m_op.wreg = 4'h0; m_op.rwe = R_NOP;
      m_op.bubble = 1'b1; m_mode = 0; m_fp = 1'b0;
    end else if (bus.exmemi_stall) begin
      m_mode = 0;
    end else begin
      m_op.instr = bus.exmemi_instr; m_op.pc = bus.exmemi_pc;
      m_op.data = bus.exmemi_data; m_op.wdata = bus.exmemi_write_to_mem_data;
      m_op.wreg = bus.exmemi_wreg_addr; m_op.rwe = bus.exmemi_rwe; m_op.bubble = 1'b0;
      m_mode = 0;
      if (m_op.rwe == R_WR && m_op.data == SERIAL) m_mode = 2;
      else if (m_op.rwe == R_WR && WR > 1) begin m_mode = 1; m_left = WR - 1; end
      else if (FEAT && m_op.rwe == R_RD && m_op.data == SERIAL) m_mode = 2;
    end
  endtask

  task automatic drv(input logic [15:0] instr, input logic [15:0] data,
                     input logic [1:0] rwe, input bit st, input bit fl,
                     input bit uw, input bit dr);
    bus.exmemi_instr             = instr;
    bus.exmemi_pc                = instr ^ 16'h5A5A;
    bus.exmemi_data              = data;
    bus.exmemi_wreg_addr         = instr[3:0];
    bus.exmemi_write_to_mem_data = ~instr;
    bus.exmemi_rwe               = rwe;
    bus.exmemi_stall             = st;
    bus.exmemi_flush             = fl;
    bus.exmemi_uart_writeable    = uw;
    bus.exmemi_uart_data_ready   = dr;
  endtask

  // One clock: compare against the model, let the edge happen, advance model.
  task automatic cyc();
    #1 compare();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [1:0] erwe, input bit es,
                     input logic [15:0] ei);
    #1;
    chk({name, ".rwe"}, bus.exmemo_rwe, erwe);
    chk({name, ".stall"}, bus.exmemo_stall_req, es);
    chk({name, ".instr"}, bus.exmemo_instr, ei);
  endtask

  initial begin
    drv(16'h1111, 16'h0001, R_NOP, 0, 0, 1, 1);
    rst = 1'b1;
    m_reset();
    @(negedge clk);
    lit("reset", R_NOP, 1'b0, NOP);
    compare();
    rst = 1'b0;

    // RAM store: two cycles of write, stall only in the first
    drv(16'h1234, 16'h4000, R_WR, 0, 0, 1, 0); cyc();
    drv(16'h2222, 16'h0005, R_NOP, 0, 0, 1, 0);
    lit("ram1", R_WR, 1'b1, 16'h1234); cyc();
    lit("ram2", R_WR, 1'b0, 16'h1234); cyc();
    lit("ram_next", R_NOP, 1'b0, 16'h2222);

    // Serial store waits five cycles for the UART
    drv(16'h3333, SERIAL, R_WR, 0, 0, 0, 0); cyc();
    drv(16'h4444, 16'h0010, R_NOP, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      lit("uart_wait", R_NOP, 1'b1, 16'h3333); cyc();
    end
    drv(16'h4444, 16'h0010, R_NOP, 0, 0, 1, 0);
    lit("uart_go", R_WR, 1'b0, 16'h3333); cyc();
    lit("uart_next", R_NOP, 1'b0, 16'h4444);

    // Flush beats stall in PASS
    drv(16'h5555, 16'h0020, R_RD, 1, 1, 1, 0); cyc();
    lit("flush_stall", R_NOP, 1'b0, NOP);

    // Flush during a RAM store hold: store completes, then a bubble
    drv(16'h6666, 16'h4000, R_WR, 0, 0, 1, 0); cyc();
    drv(16'h7777, 16'h0030, R_RD, 0, 1, 1, 0);
    lit("hold_flush1", R_WR, 1'b1, 16'h6666); cyc();
    drv(16'h7777, 16'h0030, R_RD, 0, 0, 1, 0);
    lit("hold_flush2", R_WR, 1'b0, 16'h6666); cyc();
    lit("hold_flush_bub", R_NOP, 1'b0, NOP);

    // Asynchronous reset in the middle of a held store
    drv(16'h8888, 16'h4000, R_WR, 0, 0, 1, 0); cyc();
    drv(16'h9999, 16'h0040, R_NOP, 0, 0, 1, 0);
    lit("pre_rst", R_WR, 1'b1, 16'h8888);
    rst = 1'b1;
    lit("mid_rst", R_NOP, 1'b0, NOP);
    m_reset();
    #1 rst = 1'b0;
    cyc();
    lit("post_rst", R_NOP, 1'b0, 16'h9999);

    // Serial-port load
    drv(16'hAAAA, SERIAL, R_RD, 0, 0, 1, 0); cyc();
    drv(16'hBBBB, 16'h0050, R_NOP, 0, 0, 1, 0);
`ifdef EXMEM_UART_READ_WAIT_EN
    for (int i = 0; i < 3; i++) begin
      lit("rd_wait", R_NOP, 1'b1, 16'hAAAA); cyc();
    end
    drv(16'hBBBB, 16'h0050, R_NOP, 0, 0, 1, 1);
`endif
    lit("rd_go", R_RD, 1'b0, 16'hAAAA); cyc();
    lit("rd_next", R_NOP, 1'b0, 16'hBBBB);

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [15:0] ri, rd;
      logic [1:0]  rr;
      ri = 16'($urandom);
      rr = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0, 1:    rd = SERIAL;
        2:       rd = 16'h4000;
        default: rd = 16'($urandom);
      endcase
      drv(ri, rd, rr, ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
